odd_even_sorter: RTL and testbench

ODD_EVEN_SORTER -- requirements
Module: odd_even_sorter

---
 rtl/odd_even_sorter.sv | 154 +++++++++++++++
 tb/tb_odd_even_sorter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/odd_even_sorter.sv
// Batch sorter: loads N unsigned words, sorts them with odd-even transposition
// (one phase per cycle), then streams them out smallest first.
// Optional macro ODD_EVEN_SORTER_EARLY_EXIT_EN leaves SORT early once the array is settled.
module odd_even_sorter #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SORT   = 2'd1,
    UNLOAD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  r_q [N];
  logic [W-1:0]  r_d [N];
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] phase_q, phase_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          load_fire, unload_fire, sort_done;
`ifdef ODD_EVEN_SORTER_EARLY_EXIT_EN
  logic          swap_any;
  logic          prev_swap_q, prev_swap_d;
`endif

  // Handshake: a word moves when valid and ready are both high at posedge clk;
  // ready/valid come from registered state only, never from the partner's signal.
  assign load_fire   = (state_q == LOAD) && in_valid;
  assign unload_fire = (state_q == UNLOAD) && out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = r_q[idx_q];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_fire && idx_q == LAST) state_d = SORT;
      SORT:    if (sort_done) state_d = UNLOAD;
      UNLOAD:  if (unload_fire && idx_q == LAST) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Handshake outputs are registered copies of the upcoming state
  always_comb begin
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == UNLOAD);
    busy_d      = (state_d == SORT);
  end

  always_comb begin
    r_d       = r_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    sort_done = 1'b0;
`ifdef ODD_EVEN_SORTER_EARLY_EXIT_EN
    swap_any    = 1'b0;
    prev_swap_d = prev_swap_q;
`endif
    case (state_q)
      LOAD: begin
        if (load_fire) begin
          r_d[idx_q] = in_data;
          idx_d      = (idx_q == LAST) ? '0 : idx_q + ONE;
          phase_d    = '0;
        end
      end
      SORT: begin
        // Even phases pair (0,1),(2,3)...; odd phases pair (1,2),(3,4)...
        for (int i = 0; i < N - 1; i++) begin
          if ((i % 2) == int'(phase_q[0])) begin
            if (r_q[i] > r_q[i+1]) begin
              r_d[i]   = r_q[i+1];
              r_d[i+1] = r_q[i];
`ifdef ODD_EVEN_SORTER_EARLY_EXIT_EN
              swap_any = 1'b1;
`endif
            end
          end
        end
`ifdef ODD_EVEN_SORTER_EARLY_EXIT_EN
        prev_swap_d = swap_any;
        sort_done   = (phase_q == LAST) ||
                      ((phase_q != '0) && !swap_any && !prev_swap_q);
`else
        sort_done   = (phase_q == LAST);
`endif
        phase_d = sort_done ? '0 : phase_q + ONE;
        if (sort_done) idx_d = '0;
      end
      UNLOAD: begin
        if (unload_fire) idx_d = (idx_q == LAST) ? '0 : idx_q + ONE;
      end
      default: begin
        idx_d   = '0;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_q[i] <= '0;
      idx_q   <= '0;
      phase_q <= '0;
`ifdef ODD_EVEN_SORTER_EARLY_EXIT_EN
      prev_swap_q <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < N; i++) r_q[i] <= r_d[i];
      idx_q   <= idx_d;
      phase_q <= phase_d;
`ifdef ODD_EVEN_SORTER_EARLY_EXIT_EN
      prev_swap_q <= prev_swap_d;
`endif
    end
  end

endmodule

// File: tb/tb_odd_even_sorter.sv
// Directed bench for odd_even_sorter (N=8, W=8): load/sort/unload timing,
// duplicates, output back-pressure, reset mid-sort and ignored in_valid.
module tb_odd_even_sorter;
  localparam int N = 8;
  localparam int W = 8;
`ifdef ODD_EVEN_SORTER_EARLY_EXIT_EN
  localparam int SORTED_BUSY = 2;
`else
  localparam int SORTED_BUSY = 8;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int lat;
  int busy_cnt;
  logic [W-1:0] vin  [N];
  logic [W-1:0] vexp [N];
  logic [W-1:0] exp_q[$];

  odd_even_sorter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives vin word by word; hold keeps in_valid high afterwards with in_data=0.
  task automatic load_batch(input bit hold);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = vin[i];
      check("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
    end
    if (hold) in_data = '0;
    else      in_valid = 1'b0;
  endtask

  // Called 1 cycle after the last acceptance; lat ends as the cycle index of first out_valid.
  task automatic wait_sorted();
    lat = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 200) begin
      check("in_ready_sort", in_ready, 0);
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic drain(input bit toggle);
    int c = 0;
    bit held = 1'b0;
    logic [W-1:0] held_val = '0;
    for (int i = 0; i < N; i++) exp_q.push_back(vexp[i]);
    while (exp_q.size() > 0 && c < 200) begin
      check("out_valid_unload", out_valid, 1);
      check("in_ready_unload", in_ready, 0);
      if (held) check("hold_stable", out_data, held_val);
      out_ready = toggle ? ((c % 3) == 0) : 1'b1;
      if (out_ready) begin
        check("out_data", out_data, exp_q.pop_front());
        held = 1'b0;
      end else begin
        held = 1'b1;
        held_val = out_data;
      end
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b0;
    check("drain_left", exp_q.size(), 0);
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
    check("busy_after", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);

    // Reverse order: full N-phase sort and exact latency
    vin  = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    vexp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load_batch(1'b0);
    wait_sorted();
    check("rev_latency", lat, 9);
    check("rev_busy_cycles", busy_cnt, 8);
    drain(1'b0);

    // Already sorted
    vin = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load_batch(1'b0);
    wait_sorted();
    check("sorted_busy_cycles", busy_cnt, SORTED_BUSY);
    check("sorted_latency", lat, SORTED_BUSY + 1);
    drain(1'b0);

    // Duplicates and extremes
    vin  = '{8'd3, 8'd3, 8'd0, 8'd255, 8'd3, 8'd0, 8'd255, 8'd1};
    vexp = '{8'd0, 8'd0, 8'd1, 8'd3, 8'd3, 8'd3, 8'd255, 8'd255};
    load_batch(1'b0);
    wait_sorted();
    drain(1'b0);

    // Output back-pressure pattern 1,0,0,1,0,0,...
    vin  = '{8'd200, 8'd17, 8'd3, 8'd90, 8'd17, 8'd64, 8'd0, 8'd128};
    vexp = '{8'd0, 8'd3, 8'd17, 8'd17, 8'd64, 8'd90, 8'd128, 8'd200};
    load_batch(1'b0);
    wait_sorted();
    drain(1'b1);

    // Reset during SORT phase 3 discards the batch
    vin = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd5, 8'd2, 8'd1};
    load_batch(1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_sort_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_out_data", out_data, 0);
    vin  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load_batch(1'b0);
    wait_sorted();
    drain(1'b0);

    // in_valid held high (with in_data=0) through SORT and UNLOAD
    vin  = '{8'd9, 8'd2, 8'd7, 8'd4, 8'd5, 8'd6, 8'd3, 8'd8};
    vexp = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    load_batch(1'b1);
    wait_sorted();
    drain(1'b0);
    in_valid = 1'b0;

    // Next batch must start from index 0 after the ignored in_valid
    vin  = '{8'd1, 8'd0, 8'd3, 8'd2, 8'd5, 8'd4, 8'd7, 8'd6};
    vexp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load_batch(1'b0);
    wait_sorted();
    drain(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
